// File: rtl/period_meter_pkg.sv
// rtl/period_meter_pkg.sv - shared state encoding and averaging constants for period_meter
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } state_e;

  localparam int AVG_DEPTH = 4;
  localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/period_meter_sync_edge_detect.sv
// rtl/period_meter_sync_edge_detect.sv - input synchronizer with rising-edge pulse
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // sig_i may be asynchronous; only the last stage is ever consumed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= sig_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/period_meter.sv
// rtl/period_meter.sv - clk-cycle period measurement with valid/ready result; define PERIOD_METER_AVG_EN to report 4-capture averages
module period_meter
  import period_meter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  input  logic             period_ready,
  output logic             dropped,
  output logic             timeout,
  output logic             locked
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             dropped_q, dropped_d;
  logic             timeout_q, timeout_d;
  logic             edge_det;
  logic             raw_cap;
  logic             res_cap;
  logic [WIDTH-1:0] res_val;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig_i (sig_in),
    .edge_o(edge_det)
  );

  // en low wins over everything, including an edge in the same cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    raw_cap   = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ARM;
          cnt_d   = '0;
        end
        ST_ARM: begin
          if (edge_det) begin
            cnt_d   = WIDTH'(1);
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (edge_det) begin
            raw_cap = 1'b1;
            cnt_d   = WIDTH'(1);
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ARM;
          end else begin
            cnt_d = cnt_q + WIDTH'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef PERIOD_METER_AVG_EN
  localparam int ACC_W = WIDTH + AVG_SHIFT;
  localparam int NUM_W = $clog2(AVG_DEPTH);

  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [NUM_W-1:0] num_q, num_d;

  always_comb begin
    acc_sum = acc_q + ACC_W'(cnt_q);
    acc_d   = acc_q;
    num_d   = num_q;
    res_cap = 1'b0;
    res_val = acc_sum[AVG_SHIFT +: WIDTH];
    if (state_d != ST_MEASURE) begin
      acc_d = '0;
      num_d = '0;
    end else if (raw_cap) begin
      if (num_q == NUM_W'(AVG_DEPTH - 1)) begin
        res_cap = 1'b1;
        acc_d   = '0;
        num_d   = '0;
      end else begin
        acc_d = acc_sum;
        num_d = num_q + NUM_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      num_q <= '0;
    end else begin
      acc_q <= acc_d;
      num_q <= num_d;
    end
  end
`else
  assign res_cap = raw_cap;
  assign res_val = cnt_q;
`endif

  // a fresh result beats a same-cycle accept; overwrite of an unaccepted one is sticky-flagged
  always_comb begin
    period_d  = period_q;
    valid_d   = valid_q;
    dropped_d = dropped_q;
    if (res_cap) begin
      period_d = res_val;
      valid_d  = 1'b1;
      if (valid_q && !period_ready) begin
        dropped_d = 1'b1;
      end
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
      timeout_q <= timeout_d;
    end
  end

  assign period       = period_q;
  assign period_valid = valid_q;
  assign dropped      = dropped_q;
  assign timeout      = timeout_q;
  assign locked       = (state_q == ST_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// tb/tb_period_meter.sv - randomized scoreboard bench for period_meter (WIDTH=8)
module tb_period_meter;

  localparam int W    = 8;
  localparam int LAT  = 3;      // sig_in rise to edge cycle with two sync stages
  localparam int TMAX = 255;    // 2^W-1
  localparam int MAXC = 20000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         sig_in = 1'b0;
  logic         period_ready = 1'b1;
  logic [W-1:0] period;
  logic         period_valid;
  logic         dropped;
  logic         timeout;
  logic         locked;

  period_meter #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sig_in      (sig_in),
    .period      (period),
    .period_valid(period_valid),
    .period_ready(period_ready),
    .dropped     (dropped),
    .timeout     (timeout),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  bit sig_h[MAXC];
  bit en_h[MAXC];
  bit rst_h[MAXC];
  bit nx_en = 1'b0, nx_rst = 1'b0, nx_rdy = 1'b1, rand_rdy = 1'b0;

  // reference model state: 0 idle, 1 waiting for first edge, 2 measuring
  int m_mode = 0;
  int m_last = 0;
  int m_acc = 0;
  int m_n = 0;
  int res_q[$];
  int to_q[$];
  bit exp_dropped = 1'b0;
  int n_acc = 0, n_to = 0, last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic deliver(input int v);
    int r = v;
`ifdef PERIOD_METER_AVG_EN
    m_acc += v;
    m_n++;
    if (m_n < 4) return;
    r = m_acc / 4;
    m_acc = 0;
    m_n = 0;
`endif
    if (res_q.size() != 0) begin
      res_q[0] = r;
      exp_dropped = 1'b1;
    end else begin
      res_q.push_back(r);
    end
  endtask

  task automatic model_eval(input int t);
    bit r, e, edg;
    r   = (t >= 1) ? rst_h[t-1] : 1'b0;
    e   = (t >= 1) ? en_h[t-1] : 1'b0;
    edg = (t >= LAT + 1) && sig_h[t-LAT] && !sig_h[t-LAT-1];
    if (!r) begin
      m_mode = 0;
      res_q.delete();
      to_q.delete();
      exp_dropped = 1'b0;
    end else if (!e) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (edg) begin
        m_mode = 2;
        m_last = t;
      end
    end else begin
      if (edg) begin
        deliver(t - m_last);
        m_last = t;
      end else if (t - m_last == TMAX) begin
        to_q.push_back(t);
        m_mode = 1;
      end
    end
    if (m_mode != 2) begin
      m_acc = 0;
      m_n = 0;
    end
  endtask

  task automatic step(input bit s);
    @(posedge clk);
    model_eval(cyc);
    #1;
    if (cyc >= MAXC - 1) begin
      $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    if (rand_rdy) nx_rdy = ($urandom_range(0, 3) != 0);
    sig_in = s;
    en = nx_en;
    rst_n = nx_rst;
    period_ready = nx_rdy;
    sig_h[cyc] = s;
    en_h[cyc] = nx_en;
    rst_h[cyc] = nx_rst;
    cyc++;
  endtask

  task automatic pulse_stream(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < per; i++) step(i < hi);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  // monitor: compares what the DUT presents against the scoreboard each negedge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("valid", period_valid, res_q.size() != 0);
      chk("locked", locked, m_mode == 2);
      chk("dropped", dropped, exp_dropped);
      if (timeout === 1'b1) begin
        n_to++;
        if (to_q.size() == 0) chk("spurious_timeout", 1, 0);
        else chk("timeout_cycle", cyc - 1, to_q.pop_front());
      end
      if (period_valid === 1'b1 && period_ready === 1'b1 && res_q.size() != 0) begin
        n_acc++;
        last_acc = period;
        chk("period", period, res_q.pop_front());
      end
    end
  end

  initial begin
    int a0, t0;
    step(1'b0);
    mon_en = 1'b1;
    step(1'b0);
    @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_valid", period_valid, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_locked", locked, 0);
    nx_rst = 1'b1;
    nx_en = 1'b1;
    idle(4);

    a0 = n_acc;
    pulse_stream(5, 2, 6);
    idle(4);
    chk("p5_locked", locked, 1);
`ifndef PERIOD_METER_AVG_EN
    chk("p5_count", n_acc - a0, 5);
    chk("p5_value", last_acc, 5);
`endif

    a0 = n_acc;
    pulse_stream(2, 1, 8);
    idle(3);
`ifndef PERIOD_METER_AVG_EN
    chk("p2_value", last_acc, 2);
`endif

    t0 = n_to;
    for (int i = 0; i < 300; i++) step(1'b1);
    chk("hold_high_timeouts", n_to - t0, 1);
    chk("hold_high_locked", locked, 0);
    idle(5);

    pulse_stream(10, 2, 3);
    step(1'b1);
    step(1'b1);
    step(1'b0);
    nx_rst = 1'b0;
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    chk("mid_rst_valid", period_valid, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_period", period, 0);
    nx_rst = 1'b1;
    idle(5);
    a0 = n_acc;
    pulse_stream(10, 2, 3);
    idle(4);
`ifndef PERIOD_METER_AVG_EN
    chk("post_rst_count", n_acc - a0, 2);
    chk("post_rst_value", last_acc, 10);
`endif

    pulse_stream(6, 3, 3);
    nx_en = 1'b0;
    idle(3);
    chk("gap_locked", locked, 0);
    nx_en = 1'b1;
    pulse_stream(6, 3, 4);
    idle(4);
`ifndef PERIOD_METER_AVG_EN
    chk("after_gap_value", last_acc, 6);

    nx_en = 1'b0;
    step(1'b0);
    nx_en = 1'b1;
    idle(2);
    nx_rdy = 1'b0;
    pulse_stream(7, 1, 2);
    @(negedge clk);
    chk("bp_first_valid", period_valid, 1);
    chk("bp_first_period", period, 7);
    chk("bp_first_dropped", dropped, 0);
    pulse_stream(7, 1, 1);
    @(negedge clk);
    chk("bp_over_valid", period_valid, 1);
    chk("bp_over_period", period, 7);
    chk("bp_over_dropped", dropped, 1);
    nx_rdy = 1'b1;
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    chk("bp_consumed", period_valid, 0);
`else
    nx_en = 1'b0;
    step(1'b0);
    nx_en = 1'b1;
    idle(2);
    a0 = n_acc;
    step(1'b1); idle(3);
    step(1'b1); idle(3);
    step(1'b1); idle(4);
    step(1'b1); idle(5);
    step(1'b1); idle(6);
    chk("avg_count", n_acc - a0, 1);
    chk("avg_value", last_acc, 4);
`endif

    rand_rdy = 1'b1;
    for (int r = 0; r < 40; r++) begin
      int per;
      per = $urandom_range(2, 25);
      pulse_stream(per, $urandom_range(1, per - 1), $urandom_range(2, 6));
      if ($urandom_range(0, 3) == 0) begin
        nx_en = 1'b0;
        idle($urandom_range(1, 4));
        nx_en = 1'b1;
      end
    end
    rand_rdy = 1'b0;
    nx_rdy = 1'b1;
    idle(10);
    @(negedge clk);
    chk("drain_results", res_q.size(), 0);
    chk("drain_timeouts", to_q.size(), 0);
    chk("some_results", n_acc > 20, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Receive-side counterpart of the tick generator: measures the clk-cycle interval between consecutive rising edges of an external or divided pulse stream.
- Returns the period as a number N. A stream whose rising edges are N cycles apart reports N, so the value is the inverse of the divider's num.
- Used for tempo/tap measurement and for self-check of divided clocks.
- Results are delivered over a valid/ready handshake.

Parameters:
- WIDTH, 32, counter and period width in bits.
- SYNC_STAGES, 2, synchronizer flops on sig_in (≥1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  measurement enable; low forces IDLE
- sig_in  in  1  pulse/level stream to measure (asynchronous allowed)
- period  out  WIDTH  last measured period in clk cycles
- period_valid  out  1  period holds an unconsumed result
- period_ready  in  1  consumer accepts the result when high with period_valid
- dropped  out  1  sticky: a result was overwritten before being accepted
- timeout  out  1  one-cycle pulse: counter saturated with no edge
- locked  out  1  high in MEASURE state

Behaviour:
- Reset (rst_n=0 at posedge) values:
  - period=0, period_valid=0, dropped=0, timeout=0, locked=0.
  - Counter cnt=0, state=IDLE, synchronizer flops=0.
  - Reset mid-measurement discards everything.
- sig_in passes through SYNC_STAGES flops. Edge detect = synced level is 1 and the previous synced level is 0. Call the cycle this is true "edge cycle" E.
- States:
  - IDLE: en=0. cnt held at 0; handshake outputs still operate (a pending result stays valid). en=1 → ARM.
  - ARM: waiting for the first edge. On edge: cnt<=1 → MEASURE.
  - MEASURE: each cycle without an edge: cnt<=cnt+1.
    - On edge: capture period<=cnt, period_valid<=1 at E+1, cnt<=1, stay in MEASURE.
    - cnt == 2^WIDTH-1 with no edge: timeout=1 for one cycle, cnt<=0 → ARM. No result is produced.
  - Any state, en=0 → IDLE next cycle. An edge in that same cycle is ignored.
- Period arithmetic: edges at cycles t and t+N give period=N. The minimum reportable value is 2. A constant-high or constant-low input never produces a result; it produces a timeout instead.
- Handshake:
  - A result is consumed on any cycle where period_valid and period_ready are both high; period_valid then falls next cycle.
  - period remains stable while period_valid=1 unless it is overwritten.
- Simultaneous capture and accept in the same cycle: the new result wins. period_valid stays 1 and dropped is unaffected.
- Capture while period_valid=1 and not accepted that cycle: period is overwritten, period_valid stays 1, dropped<=1.
- dropped clears only on reset.
- Latency: a sig_in rising edge reaches E after SYNC_STAGES+1 cycles; period_valid follows at E+1.

Optional Feature:
- Macro PERIOD_METER_AVG_EN.
- When defined:
  - Raw captures feed an accumulator of WIDTH+2 bits.
  - After every 4th raw capture, period<=sum>>2 (truncating) and period_valid<=1; the accumulator is cleared.
  - Entering ARM or IDLE clears the accumulator and the capture count.
  - dropped applies to averaged results only.
- When undefined: every raw capture is reported directly, as described above.

Decomposition:
- Shared package period_meter_pkg holds:
  - state enum (IDLE, ARM, MEASURE), 2 bits
  - AVG_DEPTH=4 and AVG_SHIFT=2 constants
- Sub-module sync_edge_detect (params SYNC_STAGES): synchronizer plus rising-edge pulse. It is reusable for button/tap inputs.

Test Plan:
- Period 5 stream, period_ready=1 → after the first edge, every capture gives period=5 with a one-cycle period_valid; locked=1 from the first edge onward.
- Period 2 (toggle every cycle) → period=2 repeatedly. sig_in held high → no period_valid; with WIDTH=8, timeout pulses after 255 cycles and the state returns to ARM.
- Period 7 with period_ready=0 → first result period_valid=1, period=7. Second capture → period=7 overwritten, dropped=1. Then period_ready=1 for one cycle → period_valid=0 on the next cycle.
- rst_n=0 pulse in the middle of a period 10 stream → all outputs 0. The first post-reset edge reports nothing; the second reports period=10.
- en dropped for 3 cycles during a period 6 stream → no result spanning the gap; re-arm, then period=6.
- With PERIOD_METER_AVG_EN: periods 4,4,5,6 → one result, period=4 ((4+4+5+6)>>2 = 19>>2). No intermediate period_valid.
